// File: rtl/conv33_pkg.sv
// conv33_pkg: shared FSM states and parameter-memory address map for conv33_sched.
// No ports; imported by conv33_sched and conv33_raster_cnt.
package conv33_pkg;

    typedef enum logic [2:0] {IDLE, LOAD, STREAM, DRAIN, DONE} state_t;

    localparam logic [3:0] NUM_WEIGHTS      = 4'd9;
    localparam logic [3:0] PARAM_ADDR_BIAS  = 4'd9;
    localparam logic [3:0] PARAM_ADDR_SCALE = 4'd10;

endpackage

// File: rtl/conv33_raster_cnt.sv
// conv33_raster_cnt: raster row/column counter for 3x3 window top-left coordinates.
// Ports: clk, rst (async active-low), clear (zero both counters), advance (step one window),
//        row/col (current window), wrap (advance while on the last column), last (on final window).
module conv33_raster_cnt
    import conv33_pkg::*;
#(
    parameter int IMG_W = 28,
    parameter int IMG_H = 28
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clear,
    input  logic                       advance,
    output logic [$clog2(IMG_H)-1:0]   row,
    output logic [$clog2(IMG_W)-1:0]   col,
    output logic                       wrap,
    output logic                       last
);

    localparam int RW = $clog2(IMG_H);
    localparam int CW = $clog2(IMG_W);
    localparam logic [CW-1:0] COL_END = CW'(IMG_W - 3);
    localparam logic [RW-1:0] ROW_END = RW'(IMG_H - 3);

    assign wrap = advance && col == COL_END;
    assign last = row == ROW_END && col == COL_END;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            row <= '0;
            col <= '0;
        end else if (clear) begin
            row <= '0;
            col <= '0;
        end else if (advance) begin
            col <= wrap ? '0 : col + CW'(1);
            row <= !wrap ? row : last ? '0 : row + RW'(1);
        end
    end

endmodule

// File: rtl/conv33_sched.sv
// conv33_sched: 3x3 convolution layer scheduler -- parameter load, credit-limited window
// streaming in raster order, result drain and completion pulse.
// Ports: clk, rst (async active-low), start/abort pulses; busy/done/err status;
//        param_rd_en/param_addr reads with load_*_en capture strobes one cycle later;
//        win_valid/win_ready/win_row/win_col window handshake; res_valid in, res_count out.
module conv33_sched
    import conv33_pkg::*;
#(
    parameter int IMG_W        = 28,
    parameter int IMG_H        = 28,
    parameter int MAX_INFLIGHT = 4
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic                                       start,
    input  logic                                       abort,
    output logic                                       busy,
    output logic                                       done,
    output logic                                       err,
    output logic                                       param_rd_en,
    output logic [3:0]                                 param_addr,
    output logic                                       load_weight_en,
    output logic                                       load_bias_en,
    output logic                                       load_scale_en,
    output logic                                       win_valid,
    input  logic                                       win_ready,
    output logic [$clog2(IMG_H)-1:0]                   win_row,
    output logic [$clog2(IMG_W)-1:0]                   win_col,
    input  logic                                       res_valid,
    output logic [$clog2((IMG_W-2)*(IMG_H-2)+1)-1:0]   res_count
);

    localparam int CNTW = $clog2((IMG_W - 2) * (IMG_H - 2) + 1);
    localparam logic [CNTW-1:0] RES_TOTAL = CNTW'((IMG_W - 2) * (IMG_H - 2));
    localparam logic [3:0] CREDITS   = 4'(MAX_INFLIGHT);
    localparam logic [3:0] LOAD_LAST = PARAM_ADDR_SCALE + 4'd1;

    state_t     state, state_nxt;
    logic [1:0] rst_pipe;
    logic       rst_sync;
    logic [3:0] lcnt, inflight;
    logic       xfer, wrap, last, spurious, res_ok, launch;

    // Reset asserts immediately but releases two edges later, so every flop
    // below leaves reset on a clean edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) rst_pipe <= 2'b00;
        else      rst_pipe <= {rst_pipe[0], 1'b1};
    end
    assign rst_sync = rst_pipe[1];

    assign win_valid = state == STREAM && inflight < CREDITS;
    assign xfer      = win_valid && win_ready;
    assign launch    = state == IDLE && start;
    assign spurious  = res_valid && inflight == 4'd0;
    assign res_ok    = res_valid && !spurious;

    conv33_raster_cnt #(.IMG_W(IMG_W), .IMG_H(IMG_H)) u_raster (
        .clk     (clk),
        .rst     (rst_sync),
        .clear   (launch),
        .advance (xfer),
        .row     (win_row),
        .col     (win_col),
        .wrap    (wrap),
        .last    (last)
    );

    always_ff @(posedge clk or negedge rst_sync) begin
        if (!rst_sync) state <= IDLE;
        else           state <= state_nxt;
    end

    // lcnt runs 0..11 in LOAD: reads on 0..10, and each capture strobe
    // fires on the count after its read because memory latency is one cycle.
    always_comb begin
        state_nxt      = state;
        busy           = state != IDLE;
        done           = state == DONE;
        param_rd_en    = state == LOAD && lcnt <= PARAM_ADDR_SCALE;
        param_addr     = param_rd_en ? lcnt : 4'd0;
        load_weight_en = state == LOAD && lcnt != 4'd0 && lcnt <= NUM_WEIGHTS;
        load_bias_en   = state == LOAD && lcnt == PARAM_ADDR_BIAS + 4'd1;
        load_scale_en  = state == LOAD && lcnt == LOAD_LAST;
        if (abort && state != IDLE) state_nxt = IDLE;
        else begin
            unique case (state)
                IDLE:    if (start) state_nxt = LOAD;
                LOAD:    if (lcnt == LOAD_LAST) state_nxt = STREAM;
                STREAM:  if (wrap && last) state_nxt = DRAIN;
                DRAIN:   if (res_count == RES_TOTAL) state_nxt = DONE;
                DONE:    state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_sync) begin
        if (!rst_sync) begin
            lcnt      <= 4'd0;
            inflight  <= 4'd0;
            res_count <= '0;
            err       <= 1'b0;
        end else begin
            lcnt <= state == LOAD ? lcnt + 4'd1 : 4'd0;
            if (launch) begin
                inflight  <= 4'd0;
                res_count <= '0;
                err       <= 1'b0;
            end else begin
                inflight <= inflight + {3'b000, xfer} - {3'b000, res_ok};
                if (res_ok && (state == STREAM || state == DRAIN) && res_count != RES_TOTAL)
                    res_count <= res_count + CNTW'(1);
                if (spurious) err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_conv33_sched.sv
// tb_conv33_sched: directed and randomized checks of conv33_sched (5x5 map) against a
// queue-based window/result model; two instances with MAX_INFLIGHT 4 and 2, selected by sel.
module tb_conv33_sched;

    localparam int W = 5;
    localparam int H = 5;
    localparam int NWIN = (W - 2) * (H - 2);

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0, abort = 1'b0, win_ready = 1'b0, res_valid = 1'b0;
    bit   sel = 1'b0;
    int   cyc = 0, total = 0, bad = 0;

    logic [1:0] busy_v, done_v, err_v, rd_v, lw_v, lb_v, ls_v, wv_v;
    logic [3:0] addr_v [2];
    logic [2:0] row_v [2];
    logic [2:0] col_v [2];
    logic [3:0] cnt_v [2];

    logic       busy, done, err, param_rd_en, load_weight_en, load_bias_en, load_scale_en, win_valid;
    logic [3:0] param_addr, res_count;
    logic [2:0] win_row, win_col;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        conv33_sched #(.IMG_W(W), .IMG_H(H), .MAX_INFLIGHT(g ? 2 : 4)) dut (
            .clk            (clk),
            .rst            (rst),
            .start          (start && sel == 1'(g)),
            .abort          (abort && sel == 1'(g)),
            .busy           (busy_v[g]),
            .done           (done_v[g]),
            .err            (err_v[g]),
            .param_rd_en    (rd_v[g]),
            .param_addr     (addr_v[g]),
            .load_weight_en (lw_v[g]),
            .load_bias_en   (lb_v[g]),
            .load_scale_en  (ls_v[g]),
            .win_valid      (wv_v[g]),
            .win_ready      (win_ready && sel == 1'(g)),
            .win_row        (row_v[g]),
            .win_col        (col_v[g]),
            .res_valid      (res_valid && sel == 1'(g)),
            .res_count      (cnt_v[g])
        );
    end

    assign busy           = busy_v[sel];
    assign done           = done_v[sel];
    assign err            = err_v[sel];
    assign param_rd_en    = rd_v[sel];
    assign param_addr     = addr_v[sel];
    assign load_weight_en = lw_v[sel];
    assign load_bias_en   = lb_v[sel];
    assign load_scale_en  = ls_v[sel];
    assign win_valid      = wv_v[sel];
    assign win_row        = row_v[sel];
    assign win_col        = col_v[sel];
    assign res_count      = cnt_v[sel];

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", tag, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic abort_layer();
        win_ready = 1'b0;
        res_valid = 1'b0;
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_win_valid", win_valid, 0);
    endtask

    // Pulses start and walks cycles 1..13; returns at cycle 13 (first STREAM cycle).
    task automatic start_layer(input bit chk);
        bit rd;
        start = 1'b1;
        step();
        start = 1'b0;
        check("err_cleared_by_start", err, 0);
        for (int i = 1; i <= 13; i++) begin
            rd = i <= 11;
            if (chk)
                check($sformatf("load_cycle%0d", i),
                      {param_rd_en, param_rd_en ? param_addr : 4'd0, load_weight_en, load_bias_en, load_scale_en, win_valid},
                      {rd, rd ? 4'(i - 1) : 4'd0, i >= 2 && i <= 10, i == 11, i == 12, i == 13});
            if (i < 13) step();
        end
    endtask

    // Model: expected windows as a raster list, pending results as due-edge queue,
    // outstanding count as credits used. delay=0 picks random result latency.
    task automatic run_stream(input int ready_pct, input int delay, input int stall_idx);
        int q_r[$], q_c[$], due[$];
        int outst, sent, stall, guard, dones, mx;
        bit ev, go;
        outst = 0; sent = 0; stall = 0; guard = 0; dones = 0;
        mx = sel ? 2 : 4;
        for (int r = 0; r < H - 2; r++)
            for (int c = 0; c < W - 2; c++) begin
                q_r.push_back(r);
                q_c.push_back(c);
            end
        while ((q_r.size() > 0 || due.size() > 0) && guard < 3000) begin
            ev = q_r.size() > 0 && outst < mx;
            check("win_valid", win_valid, ev);
            check("no_early_done", done, 0);
            if (ev) check("win_pos", {win_row, win_col}, {3'(q_r[0]), 3'(q_c[0])});
            go = (sent == stall_idx && stall < 5) ? 1'b0 : $urandom_range(99) < ready_pct;
            if (sent == stall_idx && ev && stall < 5) stall++;
            win_ready = go;
            res_valid = due.size() > 0 && due[0] <= cyc + 1;
            if (res_valid) begin
                void'(due.pop_front());
                outst--;
            end
            if (ev && go) begin
                void'(q_r.pop_front());
                void'(q_c.pop_front());
                outst++;
                sent++;
                due.push_back(cyc + 1 + (delay > 0 ? delay : int'($urandom_range(6, 1))));
            end
            step();
            guard++;
        end
        win_ready = 1'b0;
        res_valid = 1'b0;
        check("stream_in_budget", guard < 3000, 1);
        for (int i = 0; i < 8; i++) begin
            dones += int'(done);
            step();
        end
        check("done_pulses", dones, 1);
        check("res_count_final", res_count, NWIN);
        check("err_final", err, 0);
        check("busy_final", busy, 0);
    endtask

    initial begin
        int n, dn;
        #1 rst = 1'b0;
        step();
        check("reset_outputs",
              {busy, done, err, param_rd_en, param_addr, load_weight_en, load_bias_en, load_scale_en,
               win_valid, win_row, win_col, res_count}, 0);
        rst = 1'b1;
        repeat (3) step();
        check("idle_after_reset", busy, 0);

        // load timing + full in-order run, results 3 cycles after each transfer
        sel = 1'b0;
        start_layer(1'b1);
        run_stream(100, 3, -1);

        // spurious result in IDLE
        res_valid = 1'b1;
        step();
        res_valid = 1'b0;
        check("spurious_err", err, 1);
        check("spurious_res_count", res_count, NWIN);

        // backpressure held on window index 5 = (1,2)
        start_layer(1'b0);
        run_stream(100, 3, 5);

        // transfer and result in the same cycle with two outstanding
        start_layer(1'b0);
        win_ready = 1'b1;
        repeat (2) step();
        win_ready = 1'b1;
        res_valid = 1'b1;
        check("simul_win_valid", win_valid, 1);
        step();
        res_valid = 1'b0;
        n = 0;
        for (int i = 0; i < 8; i++) begin
            n += int'(win_valid && win_ready);
            step();
        end
        check("simul_remaining_credits", n, 2);
        check("simul_err", err, 0);
        abort_layer();

        // credit limit with MAX_INFLIGHT=2
        sel = 1'b1;
        start_layer(1'b0);
        win_ready = 1'b1;
        n = 0;
        for (int i = 0; i < 8; i++) begin
            n += int'(win_valid);
            step();
        end
        check("credit_transfers", n, 2);
        check("credit_stalled", win_valid, 0);
        win_ready = 1'b0;
        res_valid = 1'b1;
        step();
        res_valid = 1'b0;
        check("credit_resume", win_valid, 1);
        abort_layer();

        // abort after 4 transfers, then a clean rerun
        sel = 1'b0;
        start_layer(1'b0);
        win_ready = 1'b1;
        n = 0;
        for (int i = 0; i < 8; i++) begin
            n += int'(win_valid);
            step();
        end
        check("abort_pre_transfers", n, 4);
        abort_layer();
        dn = 0;
        for (int i = 0; i < 6; i++) begin
            dn += int'(done);
            step();
        end
        check("abort_no_done", dn, 0);
        start_layer(1'b0);
        run_stream(100, 3, -1);

        // randomized layers on both instances
        repeat (6) begin
            sel = 1'($urandom_range(1));
            start_layer(1'b0);
            run_stream(int'($urandom_range(100, 30)), 0, int'($urandom_range(NWIN)));
        end

        // reset asserted mid-layer with err set
        sel = 1'b0;
        start_layer(1'b0);
        res_valid = 1'b1;
        step();
        res_valid = 1'b0;
        check("stream_spurious_err", err, 1);
        check("stream_spurious_count", res_count, 0);
        win_ready = 1'b1;
        repeat (2) step();
        win_ready = 1'b0;
        rst = 1'b0;
        #1;
        check("midlayer_reset", {busy, win_valid, err, res_count, win_row, win_col}, 0);
        step();
        rst = 1'b1;
        repeat (3) step();
        check("post_reset_idle", busy, 0);
        start_layer(1'b1);
        run_stream(70, 0, -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/conv33_sched.md
CONV33_SCHED -- requirements
Module: conv33_sched

Interface
REQ-001 Parameters SHALL be: IMG_W, default 28, input map width in pixels (>=3); IMG_H, default 28, input map height in pixels (>=3); MAX_INFLIGHT, default 4, maximum issued windows awaiting results (1..15).
REQ-002 Ports SHALL be, in order:
- clk  in  1  sole clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle layer start pulse.
- abort  in  1  one-cycle abort pulse.
- busy  out  1  high while not IDLE.
- done  out  1  one-cycle pulse on layer completion.
- err  out  1  sticky result-underflow flag.
- param_rd_en  out  1  parameter memory read strobe.
- param_addr  out  4  0..8 = weights, 9 = bias, 10 = scale.
- load_weight_en  out  1  weight capture strobe.
- load_bias_en  out  1  bias capture strobe.
- load_scale_en  out  1  scale capture strobe.
- win_valid  out  1  window coordinate valid.
- win_ready  in  1  window source accepts coordinate.
- win_row  out  clog2(IMG_H)  top-left row of window.
- win_col  out  clog2(IMG_W)  top-left column of window.
- res_valid  in  1  one conv33 result produced.
- res_count  out  clog2((IMG_W-2)*(IMG_H-2)+1)  results received.

Function
REQ-003 The FSM SHALL have states IDLE, LOAD, STREAM, DRAIN, DONE, and only these.
REQ-004 In IDLE, start SHALL move the FSM to LOAD the next cycle and clear res_count, the row and column counters, and the inflight counter. start SHALL be ignored in all other states.
REQ-005 In LOAD, param_rd_en SHALL be high for 11 consecutive cycles with param_addr 0,1,...,10.
REQ-006 The parameter memory has 1-cycle read latency. load_weight_en SHALL be high the cycle after each read of addr 0..8, load_bias_en the cycle after addr 9, and load_scale_en the cycle after addr 10.
REQ-007 After the load_scale_en cycle, the FSM SHALL enter STREAM. With start sampled at cycle 0, the reads occupy cycles 1..11, the loads occupy cycles 2..12, and the first win_valid is at cycle 13.
REQ-008 In STREAM, win_valid SHALL be high when inflight < MAX_INFLIGHT and windows remain. A transfer occurs when win_valid && win_ready.
REQ-009 While win_valid is high and win_ready is low, win_row and win_col SHALL be held stable.
REQ-010 Window order SHALL be raster: win_col counts 0..IMG_W-3, then wraps to 0 and increments win_row. After row IMG_H-3, column IMG_W-3 is transferred, the FSM SHALL enter DRAIN.
REQ-011 inflight SHALL be updated as follows:
- +1 on a transfer.
- -1 on res_valid.
- unchanged when both occur in the same cycle.
REQ-012 res_count SHALL increment on every res_valid in STREAM or DRAIN, saturating at (IMG_W-2)*(IMG_H-2).
REQ-013 res_valid with inflight==0 SHALL set err and leave inflight and res_count unchanged. err SHALL clear only on reset or start.
REQ-014 DRAIN SHALL exit to DONE when res_count reaches (IMG_W-2)*(IMG_H-2). DONE SHALL assert done for exactly one cycle, then return to IDLE.
REQ-015 abort in any non-IDLE state SHALL force IDLE the next cycle. Strobes and win_valid SHALL drop the same cycle the FSM enters IDLE, and done SHALL NOT be asserted. Counters are retained until the next start.
REQ-016 busy SHALL be high in LOAD, STREAM, DRAIN and DONE.

Reset
REQ-017 On rst low, all outputs SHALL be 0 asynchronously, the FSM SHALL be in IDLE, and all counters and err SHALL be 0.
REQ-018 Release of rst SHALL be synchronized internally so that the first active edge is clean. An assertion of rst mid-layer SHALL behave like abort, plus clearing err.

Structure
REQ-019 A shared package conv33_pkg SHALL hold:
- the state enum;
- PARAM_ADDR_BIAS = 9;
- PARAM_ADDR_SCALE = 10;
- NUM_WEIGHTS = 9.
REQ-020 A single sub-module, conv33_raster_cnt, SHALL implement the row/column counters with advance, wrap and last-window outputs. All other logic SHALL be flat.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
- Load timing (IMG 5x5): start at cycle 0 -> param_addr 0..10 on cycles 1..11; load_weight_en on cycles 2..10; load_bias_en on cycle 11; load_scale_en on cycle 12; win_valid at cycle 13.
- Full run (IMG 5x5, MAX_INFLIGHT=4, win_ready=1, res_valid 3 cycles after each transfer) -> 9 windows in order (0,0)..(2,2), res_count=9, one done pulse, err=0.
- Credit limit (MAX_INFLIGHT=2, res_valid withheld) -> exactly 2 transfers, then win_valid=0 until res_valid.
- Backpressure (win_ready low for 5 cycles at window (1,2)) -> coordinates held at (1,2), no skipped windows.
- Simultaneous transfer and res_valid with inflight=2 -> inflight stays 2. Spurious res_valid in IDLE -> err=1, res_count unchanged.
- abort in STREAM after 4 transfers -> IDLE the next cycle, done never asserted. A following start reruns the full layer with res_count=9.
